// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// operand width, counter width and FSM state encoding.
package mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Optional early termination on exhausted multiplier bits: SEQ_MUL_EARLY_TERM_EN.
//
// Handshake: start is accepted on any rising edge where the FSM is in IDLE or
// DONE (start high there is the request; no ready signal, busy marks the window
// where start is ignored). done pulses for one cycle once mulresult holds the
// product; mulresult then stays stable until the next accepted operation ends.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  output logic [2*WIDTH-1:0]   mulresult,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (WIDTH == MUL_WIDTH) ? MUL_CNT_W :
                         ((WIDTH > 1) ? $clog2(WIDTH) : 1);

  mul_state_t           state;
  mul_state_t           next_state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc_upd;
  logic                 run_last;
  logic                 accept;

  assign acc_upd = b_sh[0] ? (acc + a_sh) : acc;

`ifdef SEQ_MUL_EARLY_TERM_EN
  // Stop as soon as no multiplier bits remain after this edge's shift.
  assign run_last = (count == CNT_W'(WIDTH - 1)) || ((b_sh >> 1) == '0);
`else
  assign run_last = (count == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (run_last) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          next_state = RUN;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath: operands are captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      count     <= '0;
      mulresult <= '0;
    end else if (accept) begin
      acc   <= '0;
      a_sh  <= {{WIDTH{1'b0}}, mul1};
      b_sh  <= mul2;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= acc_upd;
      a_sh  <= a_sh << 1;
      b_sh  <= b_sh >> 1;
      count <= count + CNT_W'(1);
      if (run_last) mulresult <= acc_upd;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with a product scoreboard queue;
// latency expectations follow SEQ_MUL_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;
  import mul_pkg::*;

  localparam int W = MUL_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     mul1;
  logic [W-1:0]     mul2;
  logic [2*W-1:0]   mulresult;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mul1      (mul1),
    .mul2      (mul2),
    .mulresult (mulresult),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Drive one accepted request; the edge it is sampled on is "edge 0".
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    logic [2*W-1:0] p;
    start = 1'b1;
    mul1  = a;
    mul2  = b;
    p = (2*W)'(a) * (2*W)'(b);
    if (track) exp_q.push_back(p);
    step();
    start = 1'b0;
    mul1  = W'($urandom);
    mul2  = W'($urandom);
  endtask

  // Wait for done, checking latency (edges since accept), busy and the product.
  task automatic wait_done(input string tag, input int already, input int lat);
    int cyc;
    int busy_lo;
    logic [2*W-1:0] e;
    cyc = already;
    busy_lo = 0;
    while (done !== 1'b1 && cyc < already + W + 8) begin
      if (busy !== 1'b1) busy_lo++;
      step();
      cyc++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy_in_run"}, 64'(busy_lo), 64'd0);
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, 64'(mulresult), 64'(e));
    end else begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    int p;
    int pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; mul1 = '0; mul2 = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(mulresult), 64'd0);

    // 3 x 5, then result held through idle cycles
    issue(16'd3, 16'd5, 1'b1);
    chk("t1_busy_after_accept", 64'(busy), 64'd1);
    wait_done("t1", 0, exp_lat(16'd5));
    step();
    chk("t1_done_one_cycle", 64'(done), 64'd0);
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("t1_idle_quiet", 64'(pulses), 64'd0);
    chk("t1_result_held", 64'(mulresult), 64'h0000_000F);

    // Boundary operands
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("max", 0, exp_lat(16'hFFFF));
    chk("max_const", 64'(mulresult), 64'hFFFE_0001);
    step();
    issue(16'h8000, 16'h0002, 1'b1);
    wait_done("msb", 0, exp_lat(16'h0002));
    chk("msb_const", 64'(mulresult), 64'h0001_0000);
    step();

    // Start during RUN is ignored
    p = (exp_lat(16'd9) > 5) ? 5 : exp_lat(16'd9) - 1;
    issue(16'd7, 16'd9, 1'b1);
    for (int i = 1; i < p; i++) step();
    start = 1'b1; mul1 = 16'd2; mul2 = 16'd2;
    step();
    start = 1'b0;
    wait_done("midrun", p, exp_lat(16'd9));
    chk("midrun_const", 64'(mulresult), 64'h0000_003F);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("midrun_no_second", 64'(pulses), 64'd0);

    // Reset mid-RUN aborts without a done pulse
    issue(16'd100, 16'd200, 1'b0);
    for (int i = 1; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(mulresult), 64'd0);
    step();
    chk("abort_no_done", 64'(done), 64'd0);
    issue(16'd4, 16'd4, 1'b1);
    wait_done("after_abort", 0, exp_lat(16'd4));
    chk("after_abort_const", 64'(mulresult), 64'h10);
    step();

    // Back-to-back: new start accepted in the DONE cycle
    issue(16'd6, 16'd7, 1'b1);
    wait_done("b2b_first", 0, exp_lat(16'd7));
    issue(16'h1234, 16'h0010, 1'b1);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done_low", 64'(done), 64'd0);
    chk("b2b_prev_held", 64'(mulresult), 64'd42);
    step();
    chk("b2b_prev_held_run", 64'(mulresult), 64'd42);
    wait_done("b2b_second", 1, exp_lat(16'h0010));
    chk("b2b_const", 64'(mulresult), 64'h0001_2340);
    step();

    // Operand-dependent latency cases
    issue(16'hABCD, 16'd5, 1'b1);
    wait_done("m5", 0, exp_lat(16'd5));
    step();
    issue(16'hABCD, 16'd0, 1'b1);
    wait_done("m0", 0, exp_lat(16'd0));
    chk("m0_const", 64'(mulresult), 64'd0);
    step();
    issue(16'h0000, 16'h1234, 1'b1);
    wait_done("a0", 0, exp_lat(16'h1234));
    step();
    issue(16'h0003, 16'h8000, 1'b1);
    wait_done("m8000", 0, exp_lat(16'h8000));
    chk("m8000_lat_const", 64'(exp_lat(16'h8000)), 64'd16);
    step();
    issue(16'h5555, 16'd1, 1'b1);
    wait_done("m1", 0, exp_lat(16'd1));
    step();

    // Random operands
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      issue(ra, rb, 1'b1);
      wait_done("rand", 0, exp_lat(rb));
      if (i % 2 == 0) step();
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
